// File: rtl/scarv_integ_prv_cop2pcpi_if.sv
// COP-request / PCPI signal bundle for scarv_integ_prv_cop2pcpi.
// slave = the bridge itself, master = the surrounding CPU and PCPI coprocessor.
interface scarv_integ_prv_cop2pcpi_if;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic [31:0] cpu_rs2;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport slave (
        input  cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_rs2, cpu_insn_ack,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );

    modport master (
        output cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_rs2, cpu_insn_ack,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );
endinterface

// File: rtl/scarv_integ_prv_cop2pcpi.sv
// Bridge from the SCARV COP instruction interface to a PicoRV32-style PCPI coprocessor.
// Optional no-response timeout enabled by defining SCARV_COP2PCPI_TIMEOUT_EN.
module scarv_integ_prv_cop2pcpi #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          g_clk,
    input  logic                          g_reset,
    scarv_integ_prv_cop2pcpi_if.slave     cop_pcpi
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] RES_OK      = 3'b000;
    localparam logic [2:0] RES_ILLEGAL = 3'b010;

    state_t      state_q, state_d;
    logic        accept;
    logic        done;
    logic        timeout;
    logic        rsp_taken;

    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic        rsp_q, rsp_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  result_q, result_d;

    always_ff @(posedge g_clk) begin
        if (g_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cop_pcpi.cpu_insn_req) state_d = S_ISSUE;
            S_ISSUE: if (done)                  state_d = S_RESP;
            S_RESP:  if (cop_pcpi.cpu_insn_ack) state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = (state_q == S_IDLE)  && cop_pcpi.cpu_insn_req;
        done      = (state_q == S_ISSUE) && (cop_pcpi.pcpi_ready || timeout);
        rsp_taken = (state_q == S_RESP)  && cop_pcpi.cpu_insn_ack;
    end

`ifdef SCARV_COP2PCPI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the coprocessor neither claims nor completes the instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if (state_q == S_ISSUE) begin
            if (cop_pcpi.pcpi_wait)
                cnt_d = '0;
            else if (!cop_pcpi.pcpi_ready)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign timeout = (state_q == S_ISSUE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                     !cop_pcpi.pcpi_ready && !cop_pcpi.pcpi_wait;
`else
    assign timeout = 1'b0;
`endif

    // A late pcpi_ready in the timeout cycle still takes priority over the illegal result.
    always_comb begin
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pcpi_valid_d = pcpi_valid_q;
        rsp_d        = rsp_q;
        wen_d        = wen_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        result_d     = result_q;
        if (accept) begin
            insn_d       = cop_pcpi.cpu_insn_enc;
            rs1_d        = cop_pcpi.cpu_rs1;
            rs2_d        = cop_pcpi.cpu_rs2;
            pcpi_valid_d = 1'b1;
        end
        if (done) begin
            pcpi_valid_d = 1'b0;
            rsp_d        = 1'b1;
            wen_d        = cop_pcpi.pcpi_ready && cop_pcpi.pcpi_wr;
            waddr_d      = insn_q[11:7];
            wdata_d      = (cop_pcpi.pcpi_ready && cop_pcpi.pcpi_wr) ? cop_pcpi.pcpi_rd : 32'h0;
            result_d     = cop_pcpi.pcpi_ready ? RES_OK : RES_ILLEGAL;
        end
        if (rsp_taken) begin
            rsp_d    = 1'b0;
            wen_d    = 1'b0;
            waddr_d  = 5'h0;
            wdata_d  = 32'h0;
            result_d = RES_OK;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            insn_q       <= 32'h0;
            rs1_q        <= 32'h0;
            rs2_q        <= 32'h0;
            pcpi_valid_q <= 1'b0;
            rsp_q        <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= 5'h0;
            wdata_q      <= 32'h0;
            result_q     <= RES_OK;
        end else begin
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pcpi_valid_q <= pcpi_valid_d;
            rsp_q        <= rsp_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
        end
    end

    assign cop_pcpi.cop_insn_ack = accept;
    assign cop_pcpi.pcpi_valid   = pcpi_valid_q;
    assign cop_pcpi.pcpi_insn    = insn_q;
    assign cop_pcpi.pcpi_rs1     = rs1_q;
    assign cop_pcpi.pcpi_rs2     = rs2_q;
    assign cop_pcpi.cop_insn_rsp = rsp_q;
    assign cop_pcpi.cop_wen      = wen_q;
    assign cop_pcpi.cop_waddr    = waddr_q;
    assign cop_pcpi.cop_wdata    = wdata_q;
    assign cop_pcpi.cop_result   = result_q;

endmodule

// File: tb/tb_scarv_integ_prv_cop2pcpi.sv
// Randomized self-checking bench for scarv_integ_prv_cop2pcpi acting as both CPU and PCPI device.
// Timeout scenarios run only when SCARV_COP2PCPI_TIMEOUT_EN is defined.
module tb_scarv_integ_prv_cop2pcpi;

    logic g_clk = 1'b0;
    logic g_reset;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 g_clk = ~g_clk;

    scarv_integ_prv_cop2pcpi_if bus ();

    scarv_integ_prv_cop2pcpi #(.TIMEOUT_CYCLES(16)) dut (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .cop_pcpi (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected writeback as the coprocessor protocol defines it.
    function automatic logic [31:0] exp_waddr(input logic [31:0] insn);
        return (insn / 128) % 32;
    endfunction

    function automatic logic [31:0] exp_wdata(input bit wr, input logic [31:0] rd);
        return wr ? rd : 32'h0;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp"},    32'(bus.cop_insn_rsp), 32'h0);
        chk({tag, "_wen"},    32'(bus.cop_wen),      32'h0);
        chk({tag, "_waddr"},  32'(bus.cop_waddr),    32'h0);
        chk({tag, "_wdata"},  bus.cop_wdata,         32'h0);
        chk({tag, "_result"}, 32'(bus.cop_result),   32'h0);
    endtask

    task automatic drive_idle_inputs();
        bus.cpu_insn_req = 1'b0;
        bus.cpu_insn_ack = 1'b0;
        bus.pcpi_wr      = 1'b0;
        bus.pcpi_rd      = 32'h0;
        bus.pcpi_wait    = 1'b0;
        bus.pcpi_ready   = 1'b0;
    endtask

    // One instruction: PCPI ready after rdly extra ISSUE cycles, CPU ack after adly RESP cycles.
    task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int rdly, input bit wr, input logic [31:0] rd, input int adly,
                           input bit wait_pulse);
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = insn;
        bus.cpu_rs1      = rs1;
        bus.cpu_rs2      = rs2;
        settle();
        chk("accept_ack", 32'(bus.cop_insn_ack), 32'h1);
        tick();
        bus.cpu_insn_enc = $urandom;
        bus.cpu_rs1      = $urandom;
        bus.cpu_rs2      = $urandom;
        for (int c = 0; c <= rdly; c++) begin
            bus.pcpi_ready = (c == rdly);
            bus.pcpi_wait  = wait_pulse && (c % 10 == 9);
            bus.pcpi_wr    = (c == rdly) ? wr : 1'($urandom);
            bus.pcpi_rd    = (c == rdly) ? rd : $urandom;
            settle();
            chk("issue_valid", 32'(bus.pcpi_valid),   32'h1);
            chk("issue_insn",  bus.pcpi_insn,         insn);
            chk("issue_rs1",   bus.pcpi_rs1,          rs1);
            chk("issue_rs2",   bus.pcpi_rs2,          rs2);
            chk("issue_ack0",  32'(bus.cop_insn_ack), 32'h0);
            chk("issue_rsp0",  32'(bus.cop_insn_rsp), 32'h0);
            tick();
        end
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_wr    = 1'($urandom);
        bus.pcpi_rd    = $urandom;
        settle();
        chk("resp_valid0", 32'(bus.pcpi_valid), 32'h0);
        for (int a = 0; a <= adly; a++) begin
            bus.cpu_insn_ack = (a == adly);
            settle();
            chk("resp_rsp",    32'(bus.cop_insn_rsp), 32'h1);
            chk("resp_ack0",   32'(bus.cop_insn_ack), 32'h0);
            chk("resp_wen",    32'(bus.cop_wen),      32'(wr));
            chk("resp_waddr",  32'(bus.cop_waddr),    exp_waddr(insn));
            chk("resp_wdata",  bus.cop_wdata,         exp_wdata(wr, rd));
            chk("resp_result", 32'(bus.cop_result),   32'h0);
            tick();
        end
        bus.cpu_insn_ack = 1'b0;
        bus.cpu_insn_req = 1'b0;
        settle();
        chk_quiet("post");
        chk("post_valid", 32'(bus.pcpi_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive_idle_inputs();
        bus.cpu_insn_enc = 32'h0;
        bus.cpu_rs1      = 32'h0;
        bus.cpu_rs2      = 32'h0;
        g_reset = 1'b1;
        tick();
        tick();
        g_reset = 1'b0;
        settle();
        chk_quiet("reset");
        chk("reset_valid", 32'(bus.pcpi_valid),   32'h0);
        chk("reset_ack",   32'(bus.cop_insn_ack), 32'h0);
        chk("reset_insn",  bus.pcpi_insn,         32'h0);

        // Ready in cycle 3 with writeback; CPU holds off its ack for 5 cycles.
        run_txn(32'h0000_A58B, 32'd5, 32'd7, 2, 1'b1, 32'hC, 5, 1'b1);
        // No writeback requested: data must be forced to zero.
        run_txn(32'h1234_5F33, $urandom, $urandom, 0, 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
        // Long coprocessor with periodic wait: never times out.
        run_txn($urandom, $urandom, $urandom, 40, 1'b1, $urandom, 1, 1'b1);
        // Ready exactly in the would-be timeout cycle, no wait at all: ready wins.
        run_txn($urandom, $urandom, $urandom, 15, 1'b1, $urandom, 0, 1'b0);

        for (int i = 0; i < 20; i++)
            run_txn($urandom, $urandom, $urandom, $urandom_range(0, 6), 1'($urandom),
                    $urandom, $urandom_range(0, 3), 1'b1);

        // Reset in the middle of ISSUE abandons the instruction.
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = $urandom;
        settle();
        tick();
        bus.cpu_insn_req = 1'b0;
        tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = 32'hDEAD_BEEF;
        settle();
        chk("rst_issue_valid", 32'(bus.pcpi_valid), 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk_quiet("rst_issue_quiet");
            tick();
        end
        drive_idle_inputs();
        run_txn($urandom, $urandom, $urandom, 1, 1'b1, $urandom, 0, 1'b1);

        // Reset while the response is pending.
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = 32'hFFFF_FFFF;
        settle();
        tick();
        bus.cpu_insn_req = 1'b0;
        bus.pcpi_ready   = 1'b1;
        bus.pcpi_wr      = 1'b1;
        bus.pcpi_rd      = 32'h5A5A_5A5A;
        tick();
        drive_idle_inputs();
        settle();
        chk("rst_resp_pre", 32'(bus.cop_insn_rsp), 32'h1);
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        settle();
        chk_quiet("rst_resp");
        run_txn($urandom, $urandom, $urandom, 2, 1'b0, $urandom, 2, 1'b1);

`ifdef SCARV_COP2PCPI_TIMEOUT_EN
        // Silent coprocessor: illegal result 16 cycles after pcpi_valid rises.
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = $urandom;
        settle();
        tick();
        bus.cpu_insn_req = 1'b0;
        settle();
        chk("to_valid", 32'(bus.pcpi_valid), 32'h1);
        n = 0;
        while (!bus.cop_insn_rsp && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n),                 32'd16);
        chk("to_result",  32'(bus.cop_result),    32'h2);
        chk("to_wen",     32'(bus.cop_wen),       32'h0);
        chk("to_wdata",   bus.cop_wdata,          32'h0);
        chk("to_valid0",  32'(bus.pcpi_valid),    32'h0);
        bus.cpu_insn_ack = 1'b1;
        tick();
        bus.cpu_insn_ack = 1'b0;
        settle();
        chk_quiet("to_post");
`else
        // Without the timeout the bridge waits as long as the coprocessor takes.
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = $urandom;
        settle();
        tick();
        bus.cpu_insn_req = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.cop_insn_rsp || !bus.pcpi_valid) n++;
            tick();
        end
        chk("nto_no_rsp", 32'(n), 32'd0);
        bus.pcpi_ready = 1'b1;
        tick();
        bus.pcpi_ready = 1'b0;
        settle();
        chk("nto_rsp",    32'(bus.cop_insn_rsp), 32'h1);
        chk("nto_result", 32'(bus.cop_result),   32'h0);
        bus.cpu_insn_ack = 1'b1;
        tick();
        bus.cpu_insn_ack = 1'b0;
        settle();
        chk_quiet("nto_post");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scarv_integ_prv_cop2pcpi.md
SCARV_INTEG_PRV_COP2PCPI -- requirements
Module: scarv_integ_prv_cop2pcpi

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the PCPI no-response cycles before an instruction is declared illegal.
REQ-002 SHALL have ports, one per line:
  g_clk          in   1   clock; all state updates on rising edge
  g_reset        in   1   synchronous, active-high reset
  cpu_insn_req   in   1   COP-side instruction request
  cop_insn_ack   out  1   request accepted
  cpu_insn_enc   in   32  encoded instruction
  cpu_rs1        in   32  RS1 data
  cpu_rs2        in   32  RS2 data
  cop_wen        out  1   writeback enable
  cop_waddr      out  5   writeback register address
  cop_wdata      out  32  writeback data
  cop_result     out  3   result code: 3'b000 ok, 3'b010 illegal/timeout
  cop_insn_rsp   out  1   response valid
  cpu_insn_ack   in   1   response accepted
  pcpi_valid     out  1   PCPI request valid
  pcpi_insn      out  32  PCPI instruction
  pcpi_rs1       out  32  PCPI RS1
  pcpi_rs2       out  32  PCPI RS2
  pcpi_wr        in   1   PCPI writeback request
  pcpi_rd        in   32  PCPI writeback data
  pcpi_wait      in   1   PCPI busy / instruction claimed
  pcpi_ready     in   1   PCPI done

Function
REQ-003 SHALL act as COP responder on the cpu_*/cop_* side and PCPI initiator on the pcpi_* side; one instruction in flight at a time.
REQ-004 SHALL implement FSM IDLE, ISSUE, RESP.
REQ-005 IDLE: cop_insn_ack = cpu_insn_req (combinational); on req&&ack register cpu_insn_enc/cpu_rs1/cpu_rs2, clear timeout counter, go ISSUE.
REQ-006 ISSUE: pcpi_valid=1 registered; pcpi_insn/rs1/rs2 drive the latched values, held stable for the whole state.
REQ-007 ISSUE with pcpi_ready=1: capture wen=pcpi_wr, wdata=(pcpi_wr ? pcpi_rd : 0), waddr=latched insn[11:7], result=3'b000; go RESP.
REQ-008 pcpi_valid SHALL be 0 in the cycle after pcpi_ready is sampled high.
REQ-009 Latency: request accepted in cycle 0, pcpi_valid high in cycle 1; pcpi_ready sampled in cycle k gives cop_insn_rsp high in cycle k+1.
REQ-010 RESP: cop_insn_rsp=1, with cop_wen/waddr/wdata/result held stable until cpu_insn_ack=1 is sampled; then go IDLE.
REQ-011 Outside RESP: cop_insn_rsp=0, cop_wen=0, cop_waddr/wdata/result=0.
REQ-012 cop_insn_ack SHALL be 0 in ISSUE and RESP; minimum one IDLE cycle between responses.
REQ-013 cpu_insn_enc/rs1/rs2 changes after acceptance SHALL have no effect on the in-flight instruction.

Reset
REQ-014 g_reset SHALL force IDLE, clear the counter and latched operands, and zero all registered outputs next edge.
REQ-015 Reset mid-ISSUE or mid-RESP SHALL abandon the instruction: pcpi_valid and cop_insn_rsp low the cycle after reset is sampled, no response emitted.

Configuration
REQ-016 Macro SCARV_COP2PCPI_TIMEOUT_EN defined: in ISSUE, the counter increments each cycle with pcpi_wait=0 and pcpi_ready=0 and clears on pcpi_wait=1; when it reaches TIMEOUT_CYCLES-1 with no ready, go RESP with result=3'b010, wen=0, wdata=0.
REQ-017 pcpi_ready in the timeout cycle SHALL win (result 3'b000).
REQ-018 Macro undefined: no counter logic, ISSUE waits indefinitely for pcpi_ready, result is always 3'b000.

Verification
REQ-019 insn=0x0000_A58B, rs1=5, rs2=7; PCPI ready cycle 3 with wr=1, rd=0xC -> cycle 4: rsp=1, wen=1, waddr=11, wdata=0xC, result=000.
REQ-020 Response with cpu_insn_ack held low 5 cycles -> rsp and data stable 5 cycles; ack high -> IDLE next cycle; new req accepted the following cycle.
REQ-021 pcpi_ready with pcpi_wr=0, rd=0xFFFF_FFFF -> wen=0, wdata=0, result=000.
REQ-022 TIMEOUT_EN defined, no wait/ready -> rsp 16 cycles after pcpi_valid rises with result=010, wen=0; wait pulsing every 10 cycles -> no timeout.
REQ-023 g_reset asserted during ISSUE -> pcpi_valid=0 next cycle, no rsp, next request handled normally.
